stopwatch_bcd: RTL and testbench

Centisecond stopwatch that consumes the 10 ms strobe from the clock-divider stage and keeps an MM:SS.cc time in BCD. It has start/stop, lap-freeze and clear controls, and feeds the seven-segment display driver downstream. All logic runs on the system clock; the time base enters only as a single-cycle enable strobe, never as a clock.

---
 rtl/stopwatch_pkg.sv | 26 ++
 rtl/bcd_digit_counter.sv | 28 ++
 rtl/stopwatch_bcd.sv | 128 ++++++++++++
 tb/tb_stopwatch_bcd.sv | 135 +++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and limits for the BCD stopwatch: state encoding, BCD digit
// type and the per-field count limits.
package stopwatch_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      LAP   = 2'd3
   } state_t;

   typedef logic [3:0] bcd_t;

   typedef struct packed {
      bcd_t min_tens;
      bcd_t min_ones;
      bcd_t sec_tens;
      bcd_t sec_ones;
      bcd_t cs_tens;
      bcd_t cs_ones;
   } time_t;

   localparam int CS_LIMIT  = 99;
   localparam int SEC_LIMIT = 59;

endpackage

// File: rtl/bcd_digit_counter.sv
// One BCD digit that counts 0..LIMIT; carry marks the enabled step that rolls
// the digit back to zero.
module bcd_digit_counter
   import stopwatch_pkg::*;
#(
   parameter int LIMIT = 9
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output bcd_t digit,
   output logic carry
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         digit <= '0;
      end else if (clr) begin
         digit <= '0;
      end else if (en) begin
         digit <= (digit == bcd_t'(LIMIT)) ? '0 : digit + 4'd1;
      end
   end

   assign carry = en & (digit == bcd_t'(LIMIT));

endmodule

// File: rtl/stopwatch_bcd.sv
// MM:SS.cc stopwatch: button edge detection, run/pause/lap state machine,
// six-digit BCD counter chain, lap latch and sticky overflow.
module stopwatch_bcd
   import stopwatch_pkg::*;
#(
   parameter int MINUTES_MAX = 59
) (
   input  logic clk,
   input  logic rst,
   input  logic tick_10ms,
   input  logic btn_start_stop,
   input  logic btn_lap,
   input  logic btn_clear,
   output bcd_t min_tens,
   output bcd_t min_ones,
   output bcd_t sec_tens,
   output bcd_t sec_ones,
   output bcd_t cs_tens,
   output bcd_t cs_ones,
   output logic running,
   output logic lap_active,
   output logic overflow
);

   localparam time_t MAX_TIME = {bcd_t'(MINUTES_MAX / 10), bcd_t'(MINUTES_MAX % 10),
                                 bcd_t'(SEC_LIMIT / 10),   bcd_t'(SEC_LIMIT % 10),
                                 bcd_t'(CS_LIMIT / 10),    bcd_t'(CS_LIMIT % 10)};

   state_t state;
   time_t  live;
   time_t  lap_q;
   time_t  disp;
   logic   ss_prev, lap_prev, clr_prev;
   logic   ss_edge, lap_edge, clr_edge;
   logic   inc, wrap, cnt_clr;
   logic   c_cs_ones, c_cs_tens, c_sec_ones, c_sec_tens, c_min_ones, c_min_tens;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ss_prev  <= 1'b0;
         lap_prev <= 1'b0;
         clr_prev <= 1'b0;
      end else begin
         ss_prev  <= btn_start_stop;
         lap_prev <= btn_lap;
         clr_prev <= btn_clear;
      end
   end

   assign ss_edge  = btn_start_stop & ~ss_prev;
   assign lap_edge = btn_lap & ~lap_prev;
   assign clr_edge = btn_clear & ~clr_prev;

   // Counting is gated by the state before this cycle's transition, so a tick
   // alongside a stop still counts and one alongside a start does not.
   assign inc     = tick_10ms & ((state == RUN) | (state == LAP));
   assign wrap    = c_min_tens | (inc & (live == MAX_TIME));
   assign cnt_clr = clr_edge | wrap;

   bcd_digit_counter #(.LIMIT(CS_LIMIT % 10)) u_cs_ones (
      .clk(clk), .rst(rst), .en(inc), .clr(cnt_clr), .digit(live.cs_ones), .carry(c_cs_ones));
   bcd_digit_counter #(.LIMIT(CS_LIMIT / 10)) u_cs_tens (
      .clk(clk), .rst(rst), .en(c_cs_ones), .clr(cnt_clr), .digit(live.cs_tens), .carry(c_cs_tens));
   bcd_digit_counter #(.LIMIT(SEC_LIMIT % 10)) u_sec_ones (
      .clk(clk), .rst(rst), .en(c_cs_tens), .clr(cnt_clr), .digit(live.sec_ones), .carry(c_sec_ones));
   bcd_digit_counter #(.LIMIT(SEC_LIMIT / 10)) u_sec_tens (
      .clk(clk), .rst(rst), .en(c_sec_ones), .clr(cnt_clr), .digit(live.sec_tens), .carry(c_sec_tens));
   bcd_digit_counter #(.LIMIT(9)) u_min_ones (
      .clk(clk), .rst(rst), .en(c_sec_tens), .clr(cnt_clr), .digit(live.min_ones), .carry(c_min_ones));
   bcd_digit_counter #(.LIMIT(MINUTES_MAX / 10)) u_min_tens (
      .clk(clk), .rst(rst), .en(c_min_ones), .clr(cnt_clr), .digit(live.min_tens), .carry(c_min_tens));

   // Clear outranks start_stop, which outranks lap; lower edges are dropped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         running    <= 1'b0;
         lap_active <= 1'b0;
         lap_q      <= '0;
         overflow   <= 1'b0;
      end else begin
         if (clr_edge) begin
            state      <= IDLE;
            running    <= 1'b0;
            lap_active <= 1'b0;
            lap_q      <= '0;
         end else if (ss_edge) begin
            case (state)
               RUN, LAP: begin
                  state      <= PAUSE;
                  running    <= 1'b0;
                  lap_active <= 1'b0;
               end
               default: begin
                  state      <= RUN;
                  running    <= 1'b1;
                  lap_active <= 1'b0;
               end
            endcase
         end else if (lap_edge) begin
            if (state == RUN) begin
               state      <= LAP;
               lap_active <= 1'b1;
               lap_q      <= live;
            end else if (state == LAP) begin
               state      <= RUN;
               lap_active <= 1'b0;
            end
         end

         if (clr_edge) begin
            overflow <= 1'b0;
         end else if (wrap) begin
            overflow <= 1'b1;
         end
      end
   end

   assign disp = (state == LAP) ? lap_q : live;

   assign min_tens = disp.min_tens;
   assign min_ones = disp.min_ones;
   assign sec_tens = disp.sec_tens;
   assign sec_ones = disp.sec_ones;
   assign cs_tens  = disp.cs_tens;
   assign cs_ones  = disp.cs_ones;

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Directed bench for stopwatch_bcd with MINUTES_MAX=1 so the wrap is reachable
// in a short run; expected times are written as MMSScc hex BCD.
module tb_stopwatch_bcd;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tick_10ms = 1'b0;
   logic       btn_start_stop = 1'b0;
   logic       btn_lap = 1'b0;
   logic       btn_clear = 1'b0;
   logic [3:0] min_tens, min_ones, sec_tens, sec_ones, cs_tens, cs_ones;
   logic       running, lap_active, overflow;
   int         tests = 0;
   int         failed = 0;

   stopwatch_bcd #(.MINUTES_MAX(1)) dut (
      .clk(clk), .rst(rst), .tick_10ms(tick_10ms),
      .btn_start_stop(btn_start_stop), .btn_lap(btn_lap), .btn_clear(btn_clear),
      .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
      .cs_tens(cs_tens), .cs_ones(cs_ones),
      .running(running), .lap_active(lap_active), .overflow(overflow));

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [23:0] obs, input logic [23:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_output(input string tag, input logic [23:0] exp_time,
                               input logic exp_run, input logic exp_lap, input logic exp_ovf);
      check_val({tag, " display"}, {min_tens, min_ones, sec_tens, sec_ones, cs_tens, cs_ones}, exp_time);
      check_val({tag, " running"}, {23'd0, running}, {23'd0, exp_run});
      check_val({tag, " lap_active"}, {23'd0, lap_active}, {23'd0, exp_lap});
      check_val({tag, " overflow"}, {23'd0, overflow}, {23'd0, exp_ovf});
   endtask

   // One cycle with the given buttons/tick, then one idle cycle so the next
   // press is seen as a fresh edge.
   task automatic apply_stimulus(input logic ss, input logic lap, input logic clr, input logic tk);
      btn_start_stop = ss;
      btn_lap        = lap;
      btn_clear      = clr;
      tick_10ms      = tk;
      @(posedge clk); #1;
      btn_start_stop = 1'b0;
      btn_lap        = 1'b0;
      btn_clear      = 1'b0;
      tick_10ms      = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic tick_n(input int n);
      tick_10ms = 1'b1;
      repeat (n) @(posedge clk);
      #1 tick_10ms = 1'b0;
   endtask

   initial begin
      #22 rst = 1'b0;
      @(posedge clk); #1;
      check_output("reset", 24'h000000, 1'b0, 1'b0, 1'b0);

      apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
      tick_n(150);
      check_output("run150", 24'h000150, 1'b1, 1'b0, 1'b0);

      apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0);
      check_output("clear1", 24'h000000, 1'b0, 1'b0, 1'b0);
      apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
      tick_n(42);
      check_output("pre_lap", 24'h000042, 1'b1, 1'b0, 1'b0);
      apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1);
      check_output("lap_entry", 24'h000042, 1'b1, 1'b1, 1'b0);
      tick_n(10);
      check_output("lap_hold", 24'h000042, 1'b1, 1'b1, 1'b0);
      apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
      check_output("lap_exit", 24'h000053, 1'b1, 1'b0, 1'b0);

      apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0);
      tick_n(5);
      check_output("idle_tick", 24'h000000, 1'b0, 1'b0, 1'b0);
      apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
      tick_n(500);
      check_output("run500", 24'h000500, 1'b1, 1'b0, 1'b0);
      apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
      tick_n(20);
      check_output("paused", 24'h000500, 1'b0, 1'b0, 1'b0);
      apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
      tick_n(3);
      check_output("resumed", 24'h000503, 1'b1, 1'b0, 1'b0);
      apply_stimulus(1'b1, 1'b0, 1'b0, 1'b1);
      check_output("stop_tick", 24'h000504, 1'b0, 1'b0, 1'b0);
      apply_stimulus(1'b1, 1'b0, 1'b0, 1'b1);
      check_output("start_tick", 24'h000504, 1'b1, 1'b0, 1'b0);
      apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
      apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
      check_output("lap_to_pause", 24'h000504, 1'b0, 1'b0, 1'b0);
      apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
      check_output("lap_in_pause", 24'h000504, 1'b0, 1'b0, 1'b0);
      apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
      apply_stimulus(1'b1, 1'b1, 1'b1, 1'b1);
      check_output("all_edges", 24'h000000, 1'b0, 1'b0, 1'b0);

      apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
      tick_n(11999);
      check_output("pre_wrap", 24'h015999, 1'b1, 1'b0, 1'b0);
      tick_n(1);
      check_output("wrap", 24'h000000, 1'b1, 1'b0, 1'b1);
      tick_n(1);
      check_output("after_wrap", 24'h000001, 1'b1, 1'b0, 1'b1);
      apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0);
      check_output("clear_ovf", 24'h000000, 1'b0, 1'b0, 1'b0);

      apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
      tick_n(1234);
      check_output("pre_reset", 24'h001234, 1'b1, 1'b0, 1'b0);
      #2 rst = 1'b1;
      btn_start_stop = 1'b1;
      #1 check_output("async_reset", 24'h000000, 1'b0, 1'b0, 1'b0);
      #2 rst = 1'b0;
      #1 check_output("reset_released", 24'h000000, 1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
      check_output("held_button", 24'h000000, 1'b1, 1'b0, 1'b0);
      btn_start_stop = 1'b0;
      @(posedge clk); #1;

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
